id_stage_p: RTL and testbench

- Parametrised, pipelined successor to the combinational decode stage.
- Decodes one MIPS32 instruction per cycle, reads the regfile, forwards operands from EX/MEM, and detects load-use hazards with a multi-cycle stall FSM.
- Captures the results in an internal ID/EX output register under a valid/ready handshake.
- Sits between the IF/ID register and the EX stage.

---
 rtl/id_stage_p_pkg.sv | 48 ++++
 rtl/id_stage_p_operand_fwd.sv | 33 +++
 rtl/id_stage_p.sv | 245 ++++++++++++++++++++++++
 tb/tb_id_stage_p.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_p_pkg.sv
// Shared decode constants for the pipelined ID stage:
// ALU op codes, result selects, MIPS opcode/funct fields, stall FSM states.
package id_stage_p_pkg;

    localparam logic       RstEnable    = 1'b1;
    localparam logic       WriteEnable  = 1'b1;
    localparam logic       WriteDisable = 1'b0;
    localparam logic [4:0] NOPRegAddr   = 5'b00000;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [7:0] EXE_LW_OP    = 8'b1110_0011;

    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [2:0] EXE_RES_LOAD_STORE = 3'b111;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } stall_state_e;

endpackage

// File: rtl/id_stage_p_operand_fwd.sv
// Operand select for one source: immediate when the port is unused,
// else $0 -> 0, EX forward, MEM forward, regfile data (in that priority).
// Ports: re/addr/rf_data (regfile side), ex_*/mem_* (bypass), imm, operand.
module operand_fwd #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               re,
    input  logic [RADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]  rf_data,
    input  logic               ex_wreg,
    input  logic [RADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic               mem_wreg,
    input  logic [RADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  imm,
    output logic [DATA_W-1:0]  operand
);

    always_comb begin
        operand = rf_data;
        if (!re)
            operand = imm;
        else if (addr == '0)
            operand = '0;
        else if (ex_wreg && ex_wd == addr)
            operand = ex_wdata;
        else if (mem_wreg && mem_wd == addr)
            operand = mem_wdata;
    end

endmodule

// File: rtl/id_stage_p.sv
// Pipelined MIPS32 decode stage: decode, forward, load-use stall, ID/EX reg.
// Ports: IF side (if_valid_i/pc_i/inst_i/id_ready_o), regfile reads,
// EX/MEM bypass, flush_i, EX side handshake (ex_valid_o/ex_ready_i) + payload.
module id_stage_p
    import id_stage_p_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int PC_W     = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [31:0]        inst_i,
    output logic               id_ready_o,
    output logic               reg1_read_o,
    output logic               reg2_read_o,
    output logic [RADDR_W-1:0] reg1_addr_o,
    output logic [RADDR_W-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0]  reg1_data_i,
    input  logic [DATA_W-1:0]  reg2_data_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic               ex_is_load_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic               flush_i,
    input  logic               ex_ready_i,
    output logic               ex_valid_o,
    output logic [7:0]         aluop_o,
    output logic [2:0]         alusel_o,
    output logic [DATA_W-1:0]  reg1_o,
    output logic [DATA_W-1:0]  reg2_o,
    output logic [RADDR_W-1:0] wd_o,
    output logic               wreg_o,
    output logic               inst_invalid_o,
    output logic [PC_W-1:0]    pc_o
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm16 = inst_i[15:0];

    logic [DATA_W-1:0] imm_zx, imm_sx, imm_hi;
    assign imm_zx = {{(DATA_W-16){1'b0}}, imm16};
    assign imm_sx = {{(DATA_W-16){imm16[15]}}, imm16};
    assign imm_hi = {imm16, {(DATA_W-16){1'b0}}};

    logic               re1, re2;
    logic [RADDR_W-1:0] a1, a2;
    logic [DATA_W-1:0]  imm1, imm2;
    logic [7:0]         d_aluop;
    logic [2:0]         d_alusel;
    logic [RADDR_W-1:0] d_wd;
    logic               d_wreg, d_inv;

    always_comb begin
        re1      = 1'b0;
        re2      = 1'b0;
        a1       = RADDR_W'(rs);
        a2       = RADDR_W'(rt);
        imm1     = '0;
        imm2     = '0;
        d_aluop  = EXE_NOP_OP;
        d_alusel = EXE_RES_NOP;
        d_wd     = RADDR_W'(NOPRegAddr);
        d_wreg   = WriteDisable;
        d_inv    = 1'b0;
        unique case (op)
            OP_SPECIAL: begin
                unique case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        if (sa == 5'd0) begin
                            re1      = 1'b1;
                            re2      = 1'b1;
                            d_wd     = RADDR_W'(rd);
                            d_wreg   = WriteEnable;
                            d_alusel = EXE_RES_LOGIC;
                            unique case (funct)
                                FN_AND:  d_aluop = EXE_AND_OP;
                                FN_OR:   d_aluop = EXE_OR_OP;
                                FN_XOR:  d_aluop = EXE_XOR_OP;
                                default: d_aluop = EXE_NOR_OP;
                            endcase
                        end else begin
                            d_inv = 1'b1;
                        end
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        if (rs == 5'd0) begin
                            re2      = 1'b1;
                            imm1     = DATA_W'(sa);
                            d_wd     = RADDR_W'(rd);
                            // all-zero word is the canonical NOP
                            d_wreg   = (inst_i != 32'd0);
                            d_alusel = EXE_RES_SHIFT;
                            unique case (funct)
                                FN_SLL:  d_aluop = EXE_SLL_OP;
                                FN_SRL:  d_aluop = EXE_SRL_OP;
                                default: d_aluop = EXE_SRA_OP;
                            endcase
                        end else begin
                            d_inv = 1'b1;
                        end
                    end
                    default: d_inv = 1'b1;
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                re1      = 1'b1;
                imm2     = imm_zx;
                d_wd     = RADDR_W'(rt);
                d_wreg   = WriteEnable;
                d_alusel = EXE_RES_LOGIC;
                unique case (op)
                    OP_ORI:  d_aluop = EXE_OR_OP;
                    OP_ANDI: d_aluop = EXE_AND_OP;
                    default: d_aluop = EXE_XOR_OP;
                endcase
            end
            OP_LUI: begin
                imm2     = imm_hi;
                d_wd     = RADDR_W'(rt);
                d_wreg   = WriteEnable;
                d_alusel = EXE_RES_LOGIC;
                d_aluop  = EXE_OR_OP;
            end
            OP_ADDIU: begin
                re1      = 1'b1;
                imm2     = imm_sx;
                d_wd     = RADDR_W'(rt);
                d_wreg   = WriteEnable;
                d_alusel = EXE_RES_ARITHMETIC;
                d_aluop  = EXE_ADDIU_OP;
            end
            OP_LW: begin
                re1      = 1'b1;
                imm2     = imm_sx;
                d_wd     = RADDR_W'(rt);
                d_wreg   = WriteEnable;
                d_alusel = EXE_RES_LOAD_STORE;
                d_aluop  = EXE_LW_OP;
            end
            default: d_inv = 1'b1;
        endcase
    end

    assign reg1_read_o = re1;
    assign reg2_read_o = re2;
    assign reg1_addr_o = a1;
    assign reg2_addr_o = a2;

    logic [DATA_W-1:0] op1, op2;

    operand_fwd #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd1 (
        .re(re1), .addr(a1), .rf_data(reg1_data_i),
        .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
        .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
        .imm(imm1), .operand(op1)
    );

    operand_fwd #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd2 (
        .re(re2), .addr(a2), .rf_data(reg2_data_i),
        .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i),
        .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
        .imm(imm2), .operand(op2)
    );

    // Load result not available until after EX: a consumer must wait.
    logic hazard;
    assign hazard = if_valid_i & ex_is_load_i & ex_wreg_i
                  & (ex_wd_i != '0)
                  & ((re1 & (ex_wd_i == a1)) | (re2 & (ex_wd_i == a2)));

    stall_state_e state;
    logic [2:0]   cnt;
    logic         load_en;

    assign load_en    = ~ex_valid_o | ex_ready_i;
    assign id_ready_o = (state == ST_RUN) & ~hazard & load_en & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ex_valid_o     <= 1'b0;
            aluop_o        <= EXE_NOP_OP;
            alusel_o       <= EXE_RES_NOP;
            reg1_o         <= '0;
            reg2_o         <= '0;
            wd_o           <= RADDR_W'(NOPRegAddr);
            wreg_o         <= WriteDisable;
            inst_invalid_o <= 1'b0;
            pc_o           <= '0;
            state          <= ST_RUN;
            cnt            <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
            wreg_o     <= WriteDisable;
            state      <= ST_RUN;
            cnt        <= '0;
        end else if (load_en) begin
            if (state == ST_STALL) begin
                ex_valid_o <= 1'b0;
                wreg_o     <= WriteDisable;
                if (cnt <= 3'd1) begin
                    state <= ST_RUN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end else if (hazard) begin
                ex_valid_o <= 1'b0;
                wreg_o     <= WriteDisable;
                if (LOAD_LAT > 1) begin
                    state <= ST_STALL;
                    cnt   <= 3'(LOAD_LAT - 1);
                end
            end else if (if_valid_i) begin
                ex_valid_o     <= 1'b1;
                aluop_o        <= d_aluop;
                alusel_o       <= d_alusel;
                reg1_o         <= op1;
                reg2_o         <= op2;
                wd_o           <= d_wd;
                wreg_o         <= d_wreg;
                inst_invalid_o <= d_inv;
                pc_o           <= pc_i;
            end else begin
                ex_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: table of decode/forward vectors, then
// hand-written stall, backpressure, flush and reset sequences.
module tb_id_stage_p;

    localparam logic [7:0] A_NOP = 8'h00, A_AND = 8'h24, A_OR = 8'h25;
    localparam logic [7:0] A_XOR = 8'h26, A_NOR = 8'h27, A_SLL = 8'h7C;
    localparam logic [7:0] A_SRA = 8'h03, A_ADDIU = 8'h56, A_LW = 8'hE3;
    localparam logic [2:0] S_NOP = 3'd0, S_LOG = 3'd1, S_SH = 3'd2;
    localparam logic [2:0] S_AR = 3'd4, S_LS = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] pc, inst;
    logic        id_ready, r1_re, r2_re;
    logic [4:0]  r1_a, r2_a;
    logic [31:0] r1_d, r2_d;
    logic        ex_wreg, ex_is_load, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    logic        flush, ex_ready, ex_valid;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2, pc_out;
    logic [4:0]  wd;
    logic        wreg, inv;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage_p #(.DATA_W(32), .RADDR_W(5), .PC_W(32), .LOAD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid), .pc_i(pc), .inst_i(inst),
        .id_ready_o(id_ready),
        .reg1_read_o(r1_re), .reg2_read_o(r2_re),
        .reg1_addr_o(r1_a), .reg2_addr_o(r2_a),
        .reg1_data_i(r1_d), .reg2_data_i(r2_d),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .ex_is_load_i(ex_is_load),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid),
        .aluop_o(aluop), .alusel_o(alusel),
        .reg1_o(reg1), .reg2_o(reg2), .wd_o(wd), .wreg_o(wreg),
        .inst_invalid_o(inv), .pc_o(pc_out)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] r1d, r2d;
        logic        exw;
        logic [4:0]  exd;
        logic [31:0] exdat;
        logic        mw;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic        re1, re2;
        logic [4:0]  a1, a2;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1, reg2;
        logic [4:0]  wd;
        logic        wreg, inv;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        if_valid   = 1'b0;
        pc         = '0;
        inst       = '0;
        r1_d       = '0;
        r2_d       = '0;
        ex_wreg    = 1'b0;
        ex_wd      = '0;
        ex_wdata   = '0;
        ex_is_load = 1'b0;
        mem_wreg   = 1'b0;
        mem_wd     = '0;
        mem_wdata  = '0;
        flush      = 1'b0;
        ex_ready   = 1'b1;
    endtask

    // or $3,$4,$5 while a load to $4 sits in EX
    task automatic load_use_start(input logic [31:0] p);
        idle();
        if_valid   = 1'b1;
        inst       = 32'h00851825;
        pc         = p;
        r1_d       = 32'h00004444;
        r2_d       = 32'h55550000;
        ex_is_load = 1'b1;
        ex_wreg    = 1'b1;
        ex_wd      = 5'd4;
        ex_wdata   = 32'h00000BAD;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h34011234, 32'hDEAD0001, 32'hDEAD0002,
                     1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 1,
                     A_OR, S_LOG, 32'h0, 32'h00001234, 1, 1, 0};
        vecs[1]  = '{32'h00221825, 32'h11111111, 32'h22222222,
                     1, 1, 32'hAAAA0000, 1, 1, 32'h00005555, 1, 1, 1, 2,
                     A_OR, S_LOG, 32'hAAAA0000, 32'h22222222, 3, 1, 0};
        vecs[2]  = '{32'h00221825, 32'h11111111, 32'h22222222,
                     0, 1, 32'hAAAA0000, 1, 1, 32'h00005555, 1, 1, 1, 2,
                     A_OR, S_LOG, 32'h00005555, 32'h22222222, 3, 1, 0};
        vecs[3]  = '{32'h00221825, 32'h11111111, 32'h22222222,
                     0, 1, 32'hAAAA0000, 1, 2, 32'h0BADF00D, 1, 1, 1, 2,
                     A_OR, S_LOG, 32'h11111111, 32'h0BADF00D, 3, 1, 0};
        vecs[4]  = '{32'h3C028000, 32'hDEAD0001, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 2,
                     A_OR, S_LOG, 32'h0, 32'h80000000, 2, 1, 0};
        vecs[5]  = '{32'h2402FFFF, 32'hDEAD0001, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 1, 0, 0, 2,
                     A_ADDIU, S_AR, 32'h0, 32'hFFFFFFFF, 2, 1, 0};
        vecs[6]  = '{32'h30C5FFFF, 32'h12345678, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 1, 0, 6, 5,
                     A_AND, S_LOG, 32'h12345678, 32'h0000FFFF, 5, 1, 0};
        vecs[7]  = '{32'h39078001, 32'hF0F0F0F0, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 1, 0, 8, 7,
                     A_XOR, S_LOG, 32'hF0F0F0F0, 32'h00008001, 7, 1, 0};
        vecs[8]  = '{32'h8D49FFFC, 32'h00001000, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 1, 0, 10, 9,
                     A_LW, S_LS, 32'h00001000, 32'hFFFFFFFC, 9, 1, 0};
        vecs[9]  = '{32'h018D5827, 32'h00000001, 32'h00000002,
                     0, 0, 0, 0, 0, 0, 1, 1, 12, 13,
                     A_NOR, S_LOG, 32'h1, 32'h2, 11, 1, 0};
        vecs[10] = '{32'h000F77C3, 32'hDEAD0001, 32'h80000000,
                     0, 0, 0, 0, 0, 0, 0, 1, 0, 15,
                     A_SRA, S_SH, 32'h1F, 32'h80000000, 14, 1, 0};
        vecs[11] = '{32'h00000000, 32'hDEAD0001, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                     A_SLL, S_SH, 32'h0, 32'h0, 0, 0, 0};
        vecs[12] = '{32'hFC000000, 32'hDEAD0001, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     A_NOP, S_NOP, 32'h0, 32'h0, 0, 0, 1};
        vecs[13] = '{32'h00221865, 32'hDEAD0001, 32'hDEAD0002,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     A_NOP, S_NOP, 32'h0, 32'h0, 0, 0, 1};

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_aluop", 32'(aluop), 32'(A_NOP));
        chk("rst_alusel", 32'(alusel), 32'(S_NOP));
        chk("rst_reg1", reg1, 32'd0);
        chk("rst_reg2", reg2, 32'd0);
        chk("rst_wd", 32'(wd), 32'd0);
        chk("rst_wreg", 32'(wreg), 32'd0);
        chk("rst_inv", 32'(inv), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_ready", 32'(id_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            idle();
            if_valid = 1'b1;
            pc       = 32'h100 + 32'(4 * i);
            inst     = vecs[i].inst;
            r1_d     = vecs[i].r1d;
            r2_d     = vecs[i].r2d;
            ex_wreg  = vecs[i].exw;
            ex_wd    = vecs[i].exd;
            ex_wdata = vecs[i].exdat;
            mem_wreg = vecs[i].mw;
            mem_wd   = vecs[i].md;
            mem_wdata = vecs[i].mdat;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(id_ready), 32'd1);
            chk($sformatf("v%0d_re1", i), 32'(r1_re), 32'(vecs[i].re1));
            chk($sformatf("v%0d_re2", i), 32'(r2_re), 32'(vecs[i].re2));
            if (vecs[i].re1)
                chk($sformatf("v%0d_a1", i), 32'(r1_a), 32'(vecs[i].a1));
            if (vecs[i].re2)
                chk($sformatf("v%0d_a2", i), 32'(r2_a), 32'(vecs[i].a2));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d_aluop", i), 32'(aluop), 32'(vecs[i].aluop));
            chk($sformatf("v%0d_alusel", i), 32'(alusel),
                32'(vecs[i].alusel));
            chk($sformatf("v%0d_reg1", i), reg1, vecs[i].reg1);
            chk($sformatf("v%0d_reg2", i), reg2, vecs[i].reg2);
            chk($sformatf("v%0d_wd", i), 32'(wd), 32'(vecs[i].wd));
            chk($sformatf("v%0d_wreg", i), 32'(wreg), 32'(vecs[i].wreg));
            chk($sformatf("v%0d_inv", i), 32'(inv), 32'(vecs[i].inv));
            chk($sformatf("v%0d_pc", i), pc_out, 32'h100 + 32'(4 * i));
        end

        // load-use with two stall cycles, operand then arrives via MEM
        @(negedge clk);
        load_use_start(32'h200);
        #1 chk("lu_ready_a", 32'(id_ready), 32'd0);
        @(posedge clk);
        #1 chk("lu_bubble_a", 32'(ex_valid), 32'd0);
        @(negedge clk);
        ex_is_load = 1'b0;
        ex_wreg    = 1'b0;
        #1 chk("lu_ready_b", 32'(id_ready), 32'd0);
        @(posedge clk);
        #1 chk("lu_bubble_b", 32'(ex_valid), 32'd0);
        @(negedge clk);
        mem_wreg  = 1'b1;
        mem_wd    = 5'd4;
        mem_wdata = 32'hCAFEF00D;
        #1 chk("lu_ready_c", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("lu_valid", 32'(ex_valid), 32'd1);
        chk("lu_reg1", reg1, 32'hCAFEF00D);
        chk("lu_reg2", reg2, 32'h55550000);
        chk("lu_wd", 32'(wd), 32'd3);
        chk("lu_pc", pc_out, 32'h200);

        // backpressure: output held three cycles, then back-to-back
        @(negedge clk);
        idle();
        if_valid = 1'b1;
        inst     = 32'h34010001;
        pc       = 32'h300;
        @(posedge clk);
        #1 chk("bp_a_reg2", reg2, 32'h1);
        @(negedge clk);
        inst     = 32'h34020002;
        pc       = 32'h304;
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("bp_ready%0d", k), 32'(id_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid%0d", k), 32'(ex_valid), 32'd1);
            chk($sformatf("bp_reg2_%0d", k), reg2, 32'h1);
            chk($sformatf("bp_wd%0d", k), 32'(wd), 32'd1);
            chk($sformatf("bp_pc%0d", k), pc_out, 32'h300);
            @(negedge clk);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_b_reg2", reg2, 32'h2);
        chk("bp_b_wd", 32'(wd), 32'd2);
        chk("bp_b_pc", pc_out, 32'h304);
        @(negedge clk);
        inst = 32'h34030003;
        pc   = 32'h308;
        @(posedge clk);
        #1;
        chk("bp_c_valid", 32'(ex_valid), 32'd1);
        chk("bp_c_reg2", reg2, 32'h3);
        chk("bp_c_wd", 32'(wd), 32'd3);

        // flush kills a held output register
        @(negedge clk);
        if_valid = 1'b0;
        ex_ready = 1'b0;
        flush    = 1'b1;
        #1 chk("fl_hold_ready", 32'(id_ready), 32'd0);
        @(posedge clk);
        #1 chk("fl_hold_valid", 32'(ex_valid), 32'd0);

        // flush during STALL returns the FSM to RUN
        @(negedge clk);
        load_use_start(32'h400);
        @(posedge clk);
        #1 chk("fs_bubble", 32'(ex_valid), 32'd0);
        @(negedge clk);
        ex_is_load = 1'b0;
        ex_wreg    = 1'b0;
        flush      = 1'b1;
        #1 chk("fs_ready_flush", 32'(id_ready), 32'd0);
        @(posedge clk);
        #1 chk("fs_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        idle();
        if_valid = 1'b1;
        inst     = 32'h34060066;
        pc       = 32'h404;
        #1 chk("fs_ready_run", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("fs_issue_valid", 32'(ex_valid), 32'd1);
        chk("fs_issue_reg2", reg2, 32'h66);
        chk("fs_issue_pc", pc_out, 32'h404);

        // reset in the middle of a stall
        @(negedge clk);
        load_use_start(32'h500);
        @(posedge clk);
        #1 chk("rs_bubble", 32'(ex_valid), 32'd0);
        @(negedge clk);
        ex_is_load = 1'b0;
        ex_wreg    = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1 chk("rs_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        idle();
        if_valid = 1'b1;
        inst     = 32'h34060066;
        pc       = 32'h504;
        #1 chk("rs_ready_run", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rs_issue_valid", 32'(ex_valid), 32'd1);
        chk("rs_issue_wd", 32'(wd), 32'd6);

        @(negedge clk);
        idle();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
